gmsk_burst_sequencer: RTL and testbench

GMSK_BURST_SEQUENCER -- requirements
Module: gmsk_burst_sequencer

---
 rtl/gmsk_burst_sequencer_pkg.sv | 35 +++
 rtl/gmsk_burst_sequencer.sv | 175 +++++++++++++++++
 tb/tb_gmsk_burst_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gmsk_burst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gmsk_burst_sequencer_pkg
// Description : Shared constants for the GMSK burst sequencer and gmsk_tx:
//               default burst timing and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package gmsk_burst_sequencer_pkg;

   // Default burst timing (ramp length in samples is RAMP_SYMBOLS*SAMPLES_PER_SYMBOL = 256)
   localparam int GMSK_SAMPLES_PER_SYMBOL = 128;
   localparam int GMSK_BURST_BITS         = 148;
   localparam int GMSK_RAMP_SYMBOLS       = 2;
   localparam int GMSK_GUARD_SYMBOLS      = 8;

   // Sequencer state encoding
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_RAMP_UP   = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
   localparam logic [2:0] ST_GUARD     = 3'd4;

   // One saturating step of the 8-bit amplitude envelope
   function automatic logic [7:0] ramp_step(input logic [7:0] level, input logic up);
      logic [7:0] result;
      if (up) begin
         result = (level == 8'hFF) ? level : level + 8'd1;
      end else begin
         result = (level == 8'h00) ? level : level - 8'd1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gmsk_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gmsk_burst_sequencer
// Description : Sequences one GMSK transmit burst: PA ramp-up, data symbols,
//               ramp-down and guard time, pacing bits to the modulator at the
//               symbol rate derived from the sample-rate enable.
// Revision    : 1.0 - initial release
// ============================================================================
module gmsk_burst_sequencer
   import gmsk_burst_sequencer_pkg::*;
#(
   parameter int SAMPLES_PER_SYMBOL = GMSK_SAMPLES_PER_SYMBOL,
   parameter int BURST_BITS         = GMSK_BURST_BITS,
   parameter int RAMP_SYMBOLS       = GMSK_RAMP_SYMBOLS,
   parameter int GUARD_SYMBOLS      = GMSK_GUARD_SYMBOLS
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clk_en,
   input  logic       burst_start,
   input  logic       abort,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic       bit_ready,
   output logic       mod_bit,
   output logic       mod_bit_strobe,
   output logic       pa_enable,
   output logic [7:0] ramp_level,
   output logic       burst_busy,
   output logic       burst_done,
   output logic       underrun
);

   localparam logic [6:0] SAMPLE_LAST = 7'(SAMPLES_PER_SYMBOL - 1);
   localparam logic [7:0] RAMP_LAST   = 8'(RAMP_SYMBOLS - 1);
   localparam logic [7:0] DATA_LAST   = 8'(BURST_BITS - 1);
   localparam logic [7:0] GUARD_LAST  = 8'(GUARD_SYMBOLS - 1);

   logic [2:0] state_q,    state_d;
   logic [6:0] sample_q,   sample_d;
   logic [7:0] symbol_q,   symbol_d;
   logic [7:0] ramp_q,     ramp_d;
   logic       abort_q,    abort_d;
   logic       mod_bit_q,  mod_bit_d;
   logic       strobe_q,   strobe_d;
   logic       underrun_q, underrun_d;
   logic       done_q,     done_d;
   logic       tick;

   // Symbol boundary: last sample of the current symbol on an enabled cycle
   always_comb begin
      tick = clk_en && (sample_q == SAMPLE_LAST);
   end

   // Burst FSM, counters, envelope and modulator-side next-state logic
   always_comb begin
      state_d    = state_q;
      sample_d   = sample_q;
      symbol_d   = symbol_q;
      ramp_d     = ramp_q;
      abort_d    = abort_q;
      mod_bit_d  = mod_bit_q;
      strobe_d   = 1'b0;        // pulses are one clock wide regardless of clk_en
      underrun_d = 1'b0;
      done_d     = 1'b0;

      if (clk_en && (state_q != ST_IDLE)) begin
         sample_d = tick ? 7'd0 : sample_q + 7'd1;
      end
      if (tick && (state_q != ST_IDLE)) begin
         symbol_d = symbol_q + 8'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (clk_en && burst_start) begin
               state_d  = ST_RAMP_UP;
               sample_d = 7'd0;
               symbol_d = 8'd0;
               ramp_d   = 8'd0;
               abort_d  = 1'b0;
            end
         end
         ST_RAMP_UP: begin
            if (clk_en) begin
               ramp_d = ramp_step(ramp_q, 1'b1);
               if (abort) abort_d = 1'b1;
            end
            if (tick) begin
               strobe_d  = 1'b1;
               mod_bit_d = 1'b1;
               if (symbol_q == RAMP_LAST) begin
                  symbol_d = 8'd0;
                  // an abort raised during ramp-up skips the data phase entirely
                  state_d  = abort_q ? ST_RAMP_DOWN : ST_DATA;
               end
            end
         end
         ST_DATA: begin
            ramp_d = 8'hFF;
            if (clk_en && abort) abort_d = 1'b1;
            if (tick) begin
               // the symbol slot is consumed even when no bit is offered
               strobe_d   = 1'b1;
               mod_bit_d  = bit_valid & bit_in;
               underrun_d = ~bit_valid;
               if (abort_q || (symbol_q == DATA_LAST)) begin
                  symbol_d = 8'd0;
                  state_d  = ST_RAMP_DOWN;
               end
            end
         end
         ST_RAMP_DOWN: begin
            if (clk_en) ramp_d = ramp_step(ramp_q, 1'b0);
            if (tick) begin
               strobe_d  = 1'b1;
               mod_bit_d = 1'b1;
               if (symbol_q == RAMP_LAST) begin
                  symbol_d = 8'd0;
                  state_d  = ST_GUARD;
               end
            end
         end
         ST_GUARD: begin
            ramp_d = 8'd0;
            if (tick && (symbol_q == GUARD_LAST)) begin
               symbol_d = 8'd0;
               state_d  = ST_IDLE;
               abort_d  = 1'b0;
               done_d   = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops the PA immediately, no ramp-down
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         sample_q   <= 7'd0;
         symbol_q   <= 8'd0;
         ramp_q     <= 8'd0;
         abort_q    <= 1'b0;
         mod_bit_q  <= 1'b0;
         strobe_q   <= 1'b0;
         underrun_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sample_q   <= sample_d;
         symbol_q   <= symbol_d;
         ramp_q     <= ramp_d;
         abort_q    <= abort_d;
         mod_bit_q  <= mod_bit_d;
         strobe_q   <= strobe_d;
         underrun_q <= underrun_d;
         done_q     <= done_d;
      end
   end

   assign bit_ready      = (state_q == ST_DATA) && tick;
   assign pa_enable      = (state_q == ST_RAMP_UP) || (state_q == ST_DATA) ||
                           (state_q == ST_RAMP_DOWN);
   assign burst_busy     = (state_q != ST_IDLE);
   assign ramp_level     = ramp_q;
   assign mod_bit        = mod_bit_q;
   assign mod_bit_strobe = strobe_q;
   assign underrun       = underrun_q;
   assign burst_done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gmsk_burst_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gmsk_burst_sequencer
// Description : Self-checking bench for gmsk_burst_sequencer. Expected
//               modulator symbols are queued when a burst is launched and
//               popped on each mod_bit_strobe; envelope, PA, ready and busy
//               timing are derived from the count of enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gmsk_burst_sequencer;

   localparam int SPS      = 128;
   localparam int NBITS    = 148;
   localparam int RSYM     = 2;
   localparam int GSYM     = 8;
   localparam int RAMP_LEN = RSYM * SPS;

   logic       clock = 1'b0;
   logic       reset_n, clk_en, burst_start, abort, bit_in, bit_valid;
   logic       bit_ready, mod_bit, mod_bit_strobe, pa_enable;
   logic       burst_busy, burst_done, underrun;
   logic [7:0] ramp_level;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic b;
      logic ur;
   } exp_t;
   exp_t sb_q[$];

   always #5 clock = ~clock;

   gmsk_burst_sequencer #(
      .SAMPLES_PER_SYMBOL (SPS),
      .BURST_BITS         (NBITS),
      .RAMP_SYMBOLS       (RSYM),
      .GUARD_SYMBOLS      (GSYM)
   ) u_dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .clk_en         (clk_en),
      .burst_start    (burst_start),
      .abort          (abort),
      .bit_in         (bit_in),
      .bit_valid      (bit_valid),
      .bit_ready      (bit_ready),
      .mod_bit        (mod_bit),
      .mod_bit_strobe (mod_bit_strobe),
      .pa_enable      (pa_enable),
      .ramp_level     (ramp_level),
      .burst_busy     (burst_busy),
      .burst_done     (burst_done),
      .underrun       (underrun)
   );

   // Single comparison point: counts every comparison, reports mismatches
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   // Data bit offered for data symbol k
   function automatic logic pat(input int k, input int mode);
      logic [31:0] kk;
      kk = k;
      return (mode == 0) ? kk[0] : (kk[0] ^ kk[3] ^ kk[5]);
   endfunction

   // Launch one burst and check it to completion (or to a mid-burst reset).
   // nd: data bits expected to be consumed; abort_at/rst_at: enabled-cycle
   // index for abort / reset (-1 = none); miss_a/miss_b: data symbols with no bit.
   task automatic run_burst(input int duty, input int nd, input int abort_at,
                            input int miss_a, input int miss_b, input int mode,
                            input int rst_at);
      int   en_idx, p_end, b_end, d_end, k, strobes, done_cnt, done_iter, pa_cnt;
      int   ready_bad, ramp_bad, pa_bad, busy_bad, wide_bad, stray_ur;
      logic ce, rd_exp, prev_strobe;
      logic [7:0] ramp_exp;
      exp_t e;

      d_end = RAMP_LEN + SPS * nd;
      p_end = d_end + RAMP_LEN;
      b_end = p_end + GSYM * SPS;
      en_idx = 0; strobes = 0; done_cnt = 0; done_iter = -1; pa_cnt = 0;
      ready_bad = 0; ramp_bad = 0; pa_bad = 0; busy_bad = 0; wide_bad = 0; stray_ur = 0;
      prev_strobe = 1'b0;

      sb_q.delete();
      for (int s = 0; s < RSYM; s++) begin
         e.b = 1'b1; e.ur = 1'b0; sb_q.push_back(e);
      end
      for (int d = 0; d < nd; d++) begin
         if (d == miss_a || d == miss_b) begin
            e.b = 1'b0; e.ur = 1'b1;
         end else begin
            e.b = pat(d, mode); e.ur = 1'b0;
         end
         sb_q.push_back(e);
      end
      for (int s = 0; s < RSYM; s++) begin
         e.b = 1'b1; e.ur = 1'b0; sb_q.push_back(e);
      end

      for (int i = 0; i < b_end * duty + 64; i++) begin
         @(negedge clock);
         ce          = ((i % duty) == 0);
         clk_en      = ce;
         burst_start = (i == 0) || (en_idx == 300);   // later one must be ignored
         k           = (en_idx >= RAMP_LEN) ? (en_idx - RAMP_LEN) / SPS : -1;
         bit_valid   = !((k >= 0) && (k == miss_a || k == miss_b));
         bit_in      = (k >= 0) ? (bit_valid ? pat(k, mode) : 1'b1) : 1'b0;
         abort       = ce && (i > 0) && (en_idx == abort_at);

         if ((i > 0) && (rst_at >= 0) && (en_idx == rst_at) && ce) begin
            reset_n = 1'b0;
            #1;
            chk("rst_pa_enable", pa_enable, 0);
            chk("rst_ramp_level", ramp_level, 0);
            chk("rst_burst_busy", burst_busy, 0);
            chk("rst_mod_bit", mod_bit, 0);
            chk("rst_strobe", mod_bit_strobe, 0);
            chk("rst_bit_ready", bit_ready, 0);
            repeat (3) @(negedge clock);
            reset_n = 1'b1; clk_en = 1'b0; burst_start = 1'b0; abort = 1'b0;
            sb_q.delete();
            return;
         end

         #1;
         if (i > 0) begin
            rd_exp = ce && (en_idx >= RAMP_LEN) && (en_idx < d_end) &&
                     ((en_idx % SPS) == SPS - 1);
            if (bit_ready !== rd_exp) ready_bad++;

            if (en_idx < RAMP_LEN)   ramp_exp = 8'(en_idx);
            else if (en_idx < d_end) ramp_exp = 8'hFF;
            else if (en_idx < p_end) ramp_exp = 8'(255 - (en_idx - d_end));
            else                     ramp_exp = 8'h00;
            if (ramp_level !== ramp_exp) ramp_bad++;

            if (pa_enable !== (en_idx < p_end)) pa_bad++;
            if (burst_busy !== (en_idx < b_end)) busy_bad++;
            if (pa_enable) pa_cnt++;

            if (mod_bit_strobe) begin
               strobes++;
               if (prev_strobe) wide_bad++;
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  chk("mod_bit", mod_bit, e.b);
                  chk("underrun", underrun, e.ur);
               end
            end else if (underrun) begin
               stray_ur++;
            end
            prev_strobe = mod_bit_strobe;

            if (burst_done) begin
               done_cnt++;
               if (done_iter < 0) done_iter = i;
            end
            if (ce) en_idx++;
         end
         if ((done_iter >= 0) && (i >= done_iter + 8 * duty)) break;
      end
      clk_en = 1'b0; burst_start = 1'b0; abort = 1'b0;

      chk("strobe_count", strobes, 2 * RSYM + nd);
      chk("bit_ready_timing", ready_bad, 0);
      chk("ramp_level_profile", ramp_bad, 0);
      chk("pa_enable_profile", pa_bad, 0);
      chk("burst_busy_profile", busy_bad, 0);
      chk("pa_enable_cycles", pa_cnt, p_end * duty);
      chk("burst_done_count", done_cnt, 1);
      chk("burst_done_cycle", done_iter, b_end * duty + 1);
      chk("strobe_width", wide_bad, 0);
      chk("stray_underrun", stray_ur, 0);
      chk("scoreboard_left", sb_q.size(), 0);
   endtask

   initial begin
      reset_n = 1'b0; clk_en = 1'b0; burst_start = 1'b0;
      abort = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      chk("reset_pa_enable", pa_enable, 0);
      chk("reset_ramp_level", ramp_level, 0);
      chk("reset_burst_busy", burst_busy, 0);
      chk("reset_strobe", mod_bit_strobe, 0);
      chk("reset_mod_bit", mod_bit, 0);
      chk("reset_burst_done", burst_done, 0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // abort during ramp-up: no data phase at all
      run_burst(1, 0, 100, -1, -1, 0, -1);
      // full burst, alternating bits, every bit offered
      run_burst(1, NBITS, -1, -1, -1, 0, -1);
      // abort in data symbol 50: 51 bits consumed
      run_burst(1, 51, RAMP_LEN + SPS * 50 + 64, -1, -1, 1, -1);
      // reset mid-data, then a fresh full burst with bits missing at 10 and 11
      run_burst(1, NBITS, -1, -1, -1, 0, RAMP_LEN + SPS * 5 + 30);
      repeat (2) @(negedge clock);
      run_burst(1, NBITS, -1, 10, 11, 1, -1);
      // 1-in-4 enable duty with an abort in data symbol 5
      run_burst(4, 6, RAMP_LEN + SPS * 5 + 64, -1, -1, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
